// File: rtl/ooo_pkg.sv
// Shared types and constants for the out-of-order issue logic.
// Field widths, flag bit positions, and the reservation-station entry layout
// are defined here, together with the CDB capture rule used by the source
// slots.
package ooo_pkg;

  localparam int DATA_W        = 8;
  localparam int ROBID_W       = 4;
  localparam int FLAG_WRITE_EN = 1;
  localparam int FLAG_NO_CDB   = 7;

  // One source operand: either a valid value, or a ROB tag in val[ROBID_W-1:0].
  typedef struct packed {
    logic              rdy;
    logic [DATA_W-1:0] val;
  } rs_src_t;

  // Entry layout: src[1] is the address, src[0] is the store data.
  typedef struct packed {
    logic [DATA_W-1:0]  operand;
    logic [DATA_W-1:0]  wbs;
    logic [DATA_W-1:0]  flags;
    logic [ROBID_W-1:0] robid;
    rs_src_t [1:0]      src;
  } rs_entry_t;

  // A waiting source whose tag matches a live broadcast picks up the value.
  function automatic rs_src_t src_capture(input rs_src_t            s,
                                          input logic               cv,
                                          input logic [ROBID_W-1:0] id,
                                          input logic [DATA_W-1:0]  cval);
    rs_src_t r;
    r = s;
    if (!s.rdy && cv && (s.val[ROBID_W-1:0] == id)) begin
      r.rdy = 1'b1;
      r.val = cval;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_src_slot.sv
// One source operand register of a reservation-station entry.
// A load captures the dispatched rdy/val.  A broadcast that hits the tag in
// the same cycle is captured directly, so no wakeup can be lost.  When no load
// is happening, the slot snoops the CDB and wakes itself on a tag match.
module rs_src_slot
  import ooo_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic               load_rdy,
  input  logic [DATA_W-1:0]  load_val,
  input  logic               cdb_valid,
  input  logic [ROBID_W-1:0] cdb_id,
  input  logic [DATA_W-1:0]  cdb_val,
  output logic               rdy,
  output logic [DATA_W-1:0]  val
);

  rs_src_t slot_reg;
  rs_src_t slot_next;
  rs_src_t load_src;

  assign load_src = {load_rdy, load_val};

  // Next value: a fresh load takes priority over snooping the held tag.
  always_comb begin
    slot_next = slot_reg;
    if (load_en) begin
      slot_next = src_capture(load_src, cdb_valid, cdb_id, cdb_val);
    end else begin
      slot_next = src_capture(slot_reg, cdb_valid, cdb_id, cdb_val);
    end
  end

  // Slot register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_reg <= '0;
    end else begin
      slot_reg <= slot_next;
    end
  end

  assign rdy = slot_reg.rdy;
  assign val = slot_reg.val;

endmodule

// File: rtl/ramfu_rs.sv
// In-order reservation station in front of the RAM functional unit.
// It is a circular FIFO of load/store micro-ops.  Only the head may issue,
// which keeps memory operations in program order.  Source operands wake up by
// snooping the CDB.
// Optional build macro: RAMFU_RS_ISSUE_BYPASS_EN.  When it is defined, a fully
// ready dispatch into an empty station issues in the same cycle without being
// stored.
module ramfu_rs
  import ooo_pkg::*;
#(
  parameter int DEPTH = 4  // power of two, at least 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [7:0]               disp_operand,
  input  logic [7:0]               disp_wbs,
  input  logic [7:0]               disp_flags,
  input  logic [3:0]               disp_robid,
  input  logic [1:0]               disp_src_rdy,
  input  logic [15:0]              disp_src_val,
  input  logic                     cdb_valid,
  input  logic [3:0]               cdb_id,
  input  logic [7:0]               cdb_val,
  input  logic                     flush,
  input  logic                     fu_busy,
  output logic                     input_transmit,
  output logic [7:0]               operand,
  output logic [15:0]              depvals,
  output logic [7:0]               wbs,
  output logic [7:0]               flags,
  output logic [3:0]               robid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0]   valid_reg, valid_next;
  logic [AW-1:0]      head_reg, head_next;
  logic [AW-1:0]      tail_reg, tail_next;
  logic [AW:0]        count_reg, count_next;

  logic [DATA_W-1:0]  operand_reg [DEPTH];
  logic [DATA_W-1:0]  wbs_reg     [DEPTH];
  logic [DATA_W-1:0]  flags_reg   [DEPTH];
  logic [ROBID_W-1:0] robid_reg   [DEPTH];

  // Source slots are laid out as entry*2 + source index.
  logic [2*DEPTH-1:0] slot_rdy;
  logic [DATA_W-1:0]  slot_val [2*DEPTH];
  logic [DEPTH-1:0]   load_en;

  logic [AW:0]        head_slot0, head_slot1;
  rs_entry_t          disp_entry;
  rs_entry_t          head_entry;
  logic               head_ok;
  logic               bypass;
  logic               push, pop;

  assign disp_ready = (count_reg < DEPTH_C);
  assign count      = count_reg;

  // Dispatch fields packed into the entry layout, with raw rdy/val per source.
  always_comb begin
    disp_entry         = '0;
    disp_entry.operand = disp_operand;
    disp_entry.wbs     = disp_wbs;
    disp_entry.flags   = disp_flags;
    disp_entry.robid   = disp_robid;
    disp_entry.src[0]  = {disp_src_rdy[0], disp_src_val[7:0]};
    disp_entry.src[1]  = {disp_src_rdy[1], disp_src_val[15:8]};
  end

  assign head_slot0 = {head_reg, 1'b0};
  assign head_slot1 = {head_reg, 1'b1};

  // Head view, assembled from the metadata arrays and the two source slots.
  always_comb begin
    head_entry            = '0;
    head_entry.operand    = operand_reg[head_reg];
    head_entry.wbs        = wbs_reg[head_reg];
    head_entry.flags      = flags_reg[head_reg];
    head_entry.robid      = robid_reg[head_reg];
    head_entry.src[0].rdy = slot_rdy[head_slot0];
    head_entry.src[0].val = slot_val[head_slot0];
    head_entry.src[1].rdy = slot_rdy[head_slot1];
    head_entry.src[1].val = slot_val[head_slot1];
  end

  // Readiness uses registered slot state, so an entry that wakes this cycle
  // cannot issue before the next cycle.
  assign head_ok = valid_reg[head_reg] && head_entry.src[0].rdy && head_entry.src[1].rdy;

`ifdef RAMFU_RS_ISSUE_BYPASS_EN
  rs_entry_t byp_entry;

  // Dispatch with same-cycle CDB capture applied, used only by the bypass path.
  always_comb begin
    byp_entry        = disp_entry;
    byp_entry.src[0] = src_capture(disp_entry.src[0], cdb_valid, cdb_id, cdb_val);
    byp_entry.src[1] = src_capture(disp_entry.src[1], cdb_valid, cdb_id, cdb_val);
  end

  assign bypass = (count_reg == '0) && disp_valid && byp_entry.src[0].rdy &&
                  byp_entry.src[1].rdy && !fu_busy && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign input_transmit = (head_ok || bypass) && !fu_busy && !flush;
  assign pop            = input_transmit && !bypass;
  assign push           = disp_valid && disp_ready && !flush && !bypass;

  // Issue outputs: the head entry (or the bypassed dispatch), zero when idle.
  always_comb begin
    operand = '0;
    wbs     = '0;
    flags   = '0;
    robid   = '0;
    depvals = '0;
    if (input_transmit) begin
      operand = head_entry.operand;
      wbs     = head_entry.wbs;
      flags   = head_entry.flags;
      robid   = head_entry.robid;
      depvals = {head_entry.src[1].val, head_entry.src[0].val};
`ifdef RAMFU_RS_ISSUE_BYPASS_EN
      if (bypass) begin
        operand = byp_entry.operand;
        wbs     = byp_entry.wbs;
        flags   = byp_entry.flags;
        robid   = byp_entry.robid;
        depvals = {byp_entry.src[1].val, byp_entry.src[0].val};
      end
`endif
    end
  end

  // FIFO pointer/occupancy next state.  Flush wins over push and pop.
  always_comb begin
    valid_next = valid_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      valid_next = '0;
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (pop) begin
        valid_next[head_reg] = 1'b0;
        head_next            = head_reg + 1'b1;
      end
      if (push) begin
        valid_next[tail_reg] = 1'b1;
        tail_next            = tail_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry metadata is written at tail.  No reset is needed because the valid
  // bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      operand_reg[tail_reg] <= disp_entry.operand;
      wbs_reg[tail_reg]     <= disp_entry.wbs;
      flags_reg[tail_reg]   <= disp_entry.flags;
      robid_reg[tail_reg]   <= disp_entry.robid;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign load_en[gi] = push && (tail_reg == AW'(gi));
    for (genvar gs = 0; gs < 2; gs++) begin : g_src
      rs_src_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en[gi]),
        .load_rdy  (disp_entry.src[gs].rdy),
        .load_val  (disp_entry.src[gs].val),
        .cdb_valid (cdb_valid),
        .cdb_id    (cdb_id),
        .cdb_val   (cdb_val),
        .rdy       (slot_rdy[2*gi+gs]),
        .val       (slot_val[2*gi+gs])
      );
    end
  end

endmodule

// File: tb/tb_ramfu_rs.sv
// Testbench for ramfu_rs.
// A queue-based reference model predicts every output on every cycle.
// Directed scenarios with hand-computed expectations pin the model.
// Randomized traffic then exercises dispatch, wakeup, back-pressure and flush.
`timescale 1ns/1ps
module tb_ramfu_rs;

  localparam int DEPTH = 4;
`ifdef RAMFU_RS_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [7:0]  disp_operand = '0, disp_wbs = '0, disp_flags = '0;
  logic [3:0]  disp_robid = '0;
  logic [1:0]  disp_src_rdy = '0;
  logic [15:0] disp_src_val = '0;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_id = '0;
  logic [7:0]  cdb_val = '0;
  logic        flush = 1'b0, fu_busy = 1'b0;
  logic        input_transmit;
  logic [7:0]  operand, wbs, flags;
  logic [15:0] depvals;
  logic [3:0]  robid;
  logic [2:0]  count;

  always #5 clk = ~clk;

  ramfu_rs #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_operand(disp_operand), .disp_wbs(disp_wbs), .disp_flags(disp_flags),
    .disp_robid(disp_robid), .disp_src_rdy(disp_src_rdy), .disp_src_val(disp_src_val),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
    .flush(flush), .fu_busy(fu_busy),
    .input_transmit(input_transmit), .operand(operand), .depvals(depvals),
    .wbs(wbs), .flags(flags), .robid(robid), .count(count)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] operand, wbs, flags;
    logic [3:0] robid;
    logic       rdy0, rdy1;
    logic [7:0] v0, v1;
  } ent_t;

  ent_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   cmp_en = 1'b0;

  logic        e_tx, e_byp, e_ready;
  logic [7:0]  e_op, e_wbs, e_flags;
  logic [3:0]  e_robid;
  logic [15:0] e_dep;
  int          e_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The dispatched micro-op as it would be stored, after any same-cycle
  // broadcast has satisfied a waiting tag.
  function automatic ent_t incoming();
    ent_t e;
    e.operand = disp_operand;
    e.wbs     = disp_wbs;
    e.flags   = disp_flags;
    e.robid   = disp_robid;
    e.rdy0    = disp_src_rdy[0];
    e.v0      = disp_src_val[7:0];
    e.rdy1    = disp_src_rdy[1];
    e.v1      = disp_src_val[15:8];
    if (!e.rdy0 && cdb_valid && e.v0[3:0] == cdb_id) begin e.rdy0 = 1'b1; e.v0 = cdb_val; end
    if (!e.rdy1 && cdb_valid && e.v1[3:0] == cdb_id) begin e.rdy1 = 1'b1; e.v1 = cdb_val; end
    return e;
  endfunction

  // What the outputs must be this cycle, given the queue and current inputs.
  function automatic void predict();
    ent_t d, s;
    d       = incoming();
    e_count = q.size();
    e_ready = (q.size() < DEPTH);
    e_byp   = BYP && (q.size() == 0) && disp_valid && d.rdy0 && d.rdy1 && !fu_busy && !flush;
    e_tx    = e_byp;
    if (q.size() > 0 && q[0].rdy0 && q[0].rdy1 && !fu_busy && !flush) e_tx = 1'b1;
    e_op = '0; e_wbs = '0; e_flags = '0; e_robid = '0; e_dep = '0;
    if (e_tx) begin
      if (e_byp) s = d;
      else       s = q[0];
      e_op = s.operand; e_wbs = s.wbs; e_flags = s.flags; e_robid = s.robid;
      e_dep = {s.v1, s.v0};
    end
  endfunction

  // Model state update at each edge.
  ent_t upd_d;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
    end else begin
      predict();
      if (flush) begin
        q.delete();
      end else begin
        upd_d = incoming();
        if (e_tx) $display("issue robid=%h op=%h dep=%h%s", e_robid, e_op, e_dep, e_byp ? " (bypass)" : "");
        if (e_tx && !e_byp) void'(q.pop_front());
        foreach (q[i]) begin
          if (!q[i].rdy0 && cdb_valid && q[i].v0[3:0] == cdb_id) begin q[i].rdy0 = 1'b1; q[i].v0 = cdb_val; end
          if (!q[i].rdy1 && cdb_valid && q[i].v1[3:0] == cdb_id) begin q[i].rdy1 = 1'b1; q[i].v1 = cdb_val; end
        end
        if (disp_valid && e_ready && !e_byp) q.push_back(upd_d);
      end
    end
  end

  // Per-cycle comparison, sampled between edges after inputs have settled.
  always @(negedge clk) begin
    if (cmp_en) begin
      #2;
      predict();
      chk("input_transmit", 32'(input_transmit), 32'(e_tx));
      chk("disp_ready",     32'(disp_ready),     32'(e_ready));
      chk("count",          32'(count),          32'(e_count));
      chk("operand",        32'(operand),        32'(e_op));
      chk("wbs",            32'(wbs),            32'(e_wbs));
      chk("flags",          32'(flags),          32'(e_flags));
      chk("robid",          32'(robid),          32'(e_robid));
      chk("depvals",        32'(depvals),        32'(e_dep));
    end
  end

  // ---------------- stimulus ----------------
  // Applies one cycle of inputs at the falling edge, then waits until just
  // after the model comparison so that directed literal checks can follow.
  task automatic drive(input logic dv, input logic [7:0] op, input logic [3:0] rid,
                       input logic [1:0] srdy, input logic [15:0] sval, input logic [7:0] fl,
                       input logic cv, input logic [3:0] cid, input logic [7:0] cval,
                       input logic fsh, input logic busy);
    @(negedge clk);
    disp_valid   = dv;
    disp_operand = op;
    disp_wbs     = {rid, ~rid};
    disp_flags   = fl;
    disp_robid   = rid;
    disp_src_rdy = srdy;
    disp_src_val = sval;
    cdb_valid    = cv;
    cdb_id       = cid;
    cdb_val      = cval;
    flush        = fsh;
    fu_busy      = busy;
    #3;
  endtask

  task automatic idle(input logic busy);
    drive(1'b0, 8'h00, 4'h0, 2'b00, 16'h0000, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, busy);
  endtask

  initial begin
    #1;
    chk("reset input_transmit", 32'(input_transmit), 32'(0));
    chk("reset count",          32'(count),          32'(0));
    chk("reset disp_ready",     32'(disp_ready),     32'(1));
    chk("reset depvals",        32'(depvals),        32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cmp_en = 1'b1;

    // Ready store: issues one cycle after dispatch (same cycle with bypass).
    drive(1'b1, 8'h31, 4'h1, 2'b11, 16'h105A, 8'h02, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("s1 tx at dispatch",  32'(input_transmit), 32'(BYP));
    chk("s1 dep at dispatch", 32'(depvals),        32'(BYP ? 16'h105A : 16'h0000));
    idle(1'b0);
    chk("s1 tx next",    32'(input_transmit), 32'(!BYP));
    chk("s1 dep next",   32'(depvals),        32'(BYP ? 16'h0000 : 16'h105A));
    chk("s1 flags next", 32'(flags),          32'(BYP ? 8'h00 : 8'h02));
    chk("s1 count next", 32'(count),          32'(BYP ? 0 : 1));
    idle(1'b0);
    chk("s1 count drained", 32'(count), 32'(0));

    // Load waiting on tag 3, woken by a later broadcast.
    drive(1'b1, 8'h32, 4'h2, 2'b01, 16'h0377, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    idle(1'b0);
    chk("s2 waiting", 32'(input_transmit), 32'(0));
    idle(1'b0);
    drive(1'b0, 8'h00, 4'h0, 2'b00, 16'h0000, 8'h00, 1'b1, 4'h3, 8'hFD, 1'b0, 1'b0);
    chk("s2 no issue in wake cycle", 32'(input_transmit), 32'(0));
    idle(1'b0);
    chk("s2 tx after wake", 32'(input_transmit), 32'(1));
    chk("s2 dep after wake", 32'(depvals), 32'(16'hFD77));
    idle(1'b0);

    // Tag satisfied by a broadcast in the dispatch cycle itself.
    drive(1'b1, 8'h33, 4'h3, 2'b01, 16'h0511, 8'h00, 1'b1, 4'h5, 8'h22, 1'b0, 1'b0);
    chk("s3 dep at dispatch", 32'(depvals), 32'(BYP ? 16'h2211 : 16'h0000));
    idle(1'b0);
    chk("s3 tx next",  32'(input_transmit), 32'(!BYP));
    chk("s3 dep next", 32'(depvals),        32'(BYP ? 16'h0000 : 16'h2211));
    idle(1'b0);

    // Fill while FU busy, reject a fifth dispatch, then drain in order.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 8'h40 + 8'(i), 4'(4 + i), 2'b11, {8'h50 + 8'(i), 8'h60 + 8'(i)}, 8'h02,
            1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h48, 4'h8, 2'b11, 16'h5868, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    chk("s4 full ready", 32'(disp_ready), 32'(0));
    chk("s4 full count", 32'(count),      32'(4));
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("s4 drain tx",    32'(input_transmit), 32'(1));
      chk("s4 drain robid", 32'(robid),          32'(4 + i));
    end
    idle(1'b0);
    chk("s4 empty count", 32'(count), 32'(0));

    // Non-ready head blocks a ready younger entry.
    drive(1'b1, 8'h49, 4'h9, 2'b10, 16'h4402, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h4A, 4'hA, 2'b11, 16'h6666, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("s5 blocked", 32'(input_transmit), 32'(0));
    idle(1'b0);
    chk("s5 still blocked", 32'(input_transmit), 32'(0));
    drive(1'b0, 8'h00, 4'h0, 2'b00, 16'h0000, 8'h00, 1'b1, 4'h2, 8'h77, 1'b0, 1'b0);
    chk("s5 wake cycle", 32'(input_transmit), 32'(0));
    idle(1'b0);
    chk("s5 head robid", 32'(robid),   32'(9));
    chk("s5 head dep",   32'(depvals), 32'(16'h4477));
    idle(1'b0);
    chk("s5 second robid", 32'(robid), 32'(10));
    idle(1'b0);

    // Flush with three queued entries; the flush-cycle dispatch is dropped.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 8'h70, 4'(11 + i), 2'b11, 16'h1234, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h71, 4'hE, 2'b11, 16'h1111, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
    chk("s6 no tx on flush", 32'(input_transmit), 32'(0));
    chk("s6 count pre",      32'(count),          32'(3));
    idle(1'b0);
    chk("s6 count post", 32'(count),          32'(0));
    chk("s6 tx post",    32'(input_transmit), 32'(0));

    // Asynchronous reset in the middle of an issue.
    for (int i = 0; i < 2; i++)
      drive(1'b1, 8'h80, 4'(i), 2'b11, 16'hABCD, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    idle(1'b0);
    chk("rst pre tx", 32'(input_transmit), 32'(1));
    #1 rst = 1'b0;
    cmp_en = 1'b0;
    #1;
    chk("rst async tx",    32'(input_transmit), 32'(0));
    chk("rst async count", 32'(count),          32'(0));
    chk("rst async ready", 32'(disp_ready),     32'(1));
    chk("rst async dep",   32'(depvals),        32'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    cmp_en = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom),
            ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11,
            {4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom), 4'($urandom_range(0, 3))},
            8'($urandom), ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 3)), 8'($urandom),
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0));
    end
    repeat (6) idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ramfu_rs.md
Name: ramfu_rs

Overview:
- In-order reservation station feeding the RAM functional unit. It is the transmitter side of the FU issue interface: input_transmit, operand, depvals, wbs, flags, robid and busy.
- Accepts dispatched load/store micro-ops and holds them until both source operands are ready, snooping the CDB for wakeups.
- Issues strictly oldest-first, which preserves memory ordering.

Parameters:
- DEPTH, 4: entry count; must be a power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- disp_valid  in  1  dispatch request
- disp_ready  out  1  room available; dispatch accepted when disp_valid && disp_ready
- disp_operand  in  8  opcode/operand byte
- disp_wbs  in  8  writeback selector
- disp_flags  in  8  flags; bit1 = write enable, bit7 = suppress CDB
- disp_robid  in  4  ROB id
- disp_src_rdy  in  2  per source: 1 = value valid, 0 = waiting on tag
- disp_src_val  in  2x8  value, or ROB tag in bits [3:0] when not ready; [1] = address, [0] = store data
- cdb_valid  in  1  CDB broadcast
- cdb_id  in  4  broadcast ROB id
- cdb_val  in  8  broadcast value
- flush  in  1  synchronous squash of all entries
- fu_busy  in  1  FU busy (FU's busy output)
- input_transmit  out  1  issue strobe to FU
- operand  out  8  issued operand
- depvals  out  2x8  issued source values
- wbs  out  8  issued wbs
- flags  out  8  issued flags
- robid  out  4  issued ROB id
- count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst low, async): all entries invalid, head = tail = 0, count = 0, disp_ready = 1, input_transmit = 0. Issue data outputs are 0 while no issue is in progress.
- Storage: circular FIFO. Each entry holds operand, wbs, flags, robid, and per source a rdy bit plus an 8-bit val/tag. head/tail wrap modulo DEPTH.
- Dispatch: on an accepted dispatch, write the entry at tail and increment tail.
  - If cdb_valid and a not-ready source tag equals cdb_id in that same cycle, the source is written ready with cdb_val. No lost wakeups.
- Wakeup: every cycle, for every valid entry and source with rdy = 0 and val[3:0] == cdb_id while cdb_valid: set val = cdb_val and rdy = 1 at the edge.
- Issue (combinational from head):
  - input_transmit = head valid && both head sources rdy && !fu_busy && !flush.
  - Data outputs mirror the head entry while input_transmit is high, else 0.
  - On the clock edge with input_transmit high, pop head.
- Issue latency: minimum 1 cycle from dispatch to input_transmit (base build).
- No reordering: a ready younger entry waits behind a non-ready head.
- disp_ready = (count < DEPTH). It is computed from the registered count, so when full, a same-cycle pop does not admit a dispatch.
- count: +1 on accepted dispatch, -1 on issue, unchanged when both occur.
- Flush:
  - At the edge, all entries are invalidated and head = tail = count = 0.
  - A dispatch in the flush cycle is dropped.
  - input_transmit is 0 in the flush cycle.
- Wakeup and issue of the same entry never coincide: a waking entry issues no earlier than the next cycle.
- Reset asserted mid-operation clears state immediately. Outputs return to reset values without waiting for clk.

Optional Feature:
- Macro: RAMFU_RS_ISSUE_BYPASS_EN.
- With the macro defined: when the FIFO is empty, the dispatch has both sources ready (after same-cycle CDB capture), !fu_busy and !flush, input_transmit asserts in the dispatch cycle. Outputs are driven from the disp_* fields and the entry is not written (0-cycle latency).
- Without the macro: behaviour is exactly the base build, with minimum latency of 1 cycle.

Decomposition:
- Package ooo_pkg:
  - DATA_W = 8, ROBID_W = 4
  - FLAG_WRITE_EN = 1, FLAG_NO_CDB = 7
  - typedef rs_src_t {rdy, val}
  - typedef rs_entry_t {operand, wbs, flags, robid, rs_src_t src[2]}
- Sub-module rs_src_slot: one source operand register holding rdy and val. It takes a load port and CDB snoop inputs and outputs rdy and val. It is instantiated 2×DEPTH times.

Test Plan:
- Reset, then dispatch a store with src[1] = 8'h10 ready, src[0] = 8'h5A ready, flags = 8'h02 → next cycle input_transmit = 1, depvals = {8'h10, 8'h5A}, flags = 8'h02; count goes 1 → 0.
- Dispatch a load with src[1] waiting on tag 3; after 2 cycles drive cdb_valid, cdb_id = 3, cdb_val = 8'hFD → input_transmit high the following cycle with depvals[1] = 8'hFD.
- Dispatch with a not-ready tag 5 while cdb_valid, cdb_id = 5, cdb_val = 8'h22 in the same cycle → entry issues next cycle with value 8'h22; no hang.
- Fill 4 entries with fu_busy = 1 → disp_ready = 0 and count = 4. A fifth dispatch is ignored. Release fu_busy → 4 issues in dispatch order on consecutive cycles.
- Head waits on tag 2 while entry 1 is ready → no issue until the tag-2 broadcast, then head issues, then entry 1.
- With 3 entries queued, pulse flush → count = 0 and no input_transmit. Rerun scenario 1 with RAMFU_RS_ISSUE_BYPASS_EN defined → input_transmit in the dispatch cycle.
